aes_core_ctrl: RTL and testbench

Top-level sequencer for the AES core. It accepts key-expansion and block-encryption commands, drives the key-memory and encipher engines through their start/ready handshakes, and owns the single shared 32-bit S-box (muxing its input between the two engines). It latches the plaintext on command and holds the ciphertext result. It also enforces command legality and a per-operation watchdog.

---
 rtl/aes_pkg.sv | 34 +++
 rtl/aes_core_ctrl.sv | 175 +++++++++++++++++
 tb/tb_aes_core_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length encodings, round counts and the
// controller state encoding used by aes_core_ctrl.
package aes_pkg;

  localparam logic [1:0] AES_128_BIT_KEY = 2'd0;
  localparam logic [1:0] AES_192_BIT_KEY = 2'd1;
  localparam logic [1:0] AES_256_BIT_KEY = 2'd2;

  localparam int AES_128_ROUNDS = 10;
  localparam int AES_192_ROUNDS = 12;
  localparam int AES_256_ROUNDS = 14;

  typedef enum logic [2:0] {
    CTRL_IDLE      = 3'd0,
    CTRL_KEY_START = 3'd1,
    CTRL_KEY_WAIT  = 3'd2,
    CTRL_ENC_START = 3'd3,
    CTRL_ENC_WAIT  = 3'd4
  } ctrl_state_t;

  function automatic logic keylen_legal(input logic [1:0] kl);
    return (kl == AES_128_BIT_KEY) || (kl == AES_192_BIT_KEY) ||
           (kl == AES_256_BIT_KEY);
  endfunction

  function automatic int num_rounds(input logic [1:0] kl);
    case (kl)
      AES_192_BIT_KEY: return AES_192_ROUNDS;
      AES_256_BIT_KEY: return AES_256_ROUNDS;
      default:         return AES_128_ROUNDS;
    endcase
  endfunction

endpackage

// File: rtl/aes_core_ctrl.sv
// AES core sequencer: accepts init/next commands, handshakes with the key
// memory and encipher engines, owns the shared S-box input mux and a watchdog.
module aes_core_ctrl
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic         next,
  input  logic [1:0]   keylen,
  input  logic [127:0] block_in,
  output logic         ready,
  output logic         key_valid,
  output logic [127:0] result,
  output logic         result_valid,
  output logic         error,
  output logic [1:0]   keylen_o,
  output logic         km_init,
  input  logic         km_ready,
  input  logic [31:0]  km_sboxw,
  output logic         enc_next,
  input  logic         enc_ready,
  input  logic [31:0]  enc_sboxw,
  output logic [127:0] enc_block,
  input  logic [127:0] enc_new_block,
  output logic [31:0]  sboxw
);

  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

  ctrl_state_t         r_state;
  ctrl_state_t         w_state_next;
  logic [WDOG_W-1:0]   r_wdog;
  logic [WDOG_W-1:0]   w_wdog_next;
  logic                r_ready;
  logic                r_key_valid;
  logic                r_result_valid;
  logic                r_error;
  logic                r_km_init;
  logic                r_enc_next;
  logic [1:0]          r_keylen;
  logic [127:0]        r_enc_block;
  logic [127:0]        r_result;
  logic                w_error;
  logic                w_accept_init;
  logic                w_accept_next;
  logic                w_key_done;
  logic                w_enc_done;

  always_comb begin
    w_state_next  = r_state;
    w_wdog_next   = r_wdog;
    w_error       = 1'b0;
    w_accept_init = 1'b0;
    w_accept_next = 1'b0;
    w_key_done    = 1'b0;
    w_enc_done    = 1'b0;
    case (r_state)
      CTRL_IDLE: begin
        // init wins over a simultaneous next; the next is dropped silently
        if (init) begin
          if (keylen_legal(keylen)) begin
            w_accept_init = 1'b1;
            w_state_next  = CTRL_KEY_START;
          end else begin
            w_error = 1'b1;
          end
        end else if (next) begin
          if (r_key_valid) begin
            w_accept_next = 1'b1;
            w_state_next  = CTRL_ENC_START;
          end else begin
            w_error = 1'b1;
          end
        end
      end
      CTRL_KEY_START: begin
        w_error      = init | next;
        w_wdog_next  = '0;
        w_state_next = CTRL_KEY_WAIT;
      end
      CTRL_ENC_START: begin
        w_error      = init | next;
        w_wdog_next  = '0;
        w_state_next = CTRL_ENC_WAIT;
      end
      CTRL_KEY_WAIT: begin
        w_error = init | next;
        if (km_ready) begin
          w_key_done   = 1'b1;
          w_state_next = CTRL_IDLE;
        end else if (r_wdog == WDOG_LAST) begin
          w_error      = 1'b1;
          w_state_next = CTRL_IDLE;
        end else begin
          w_wdog_next = r_wdog + 1'b1;
        end
      end
      CTRL_ENC_WAIT: begin
        w_error = init | next;
        if (enc_ready) begin
          w_enc_done   = 1'b1;
          w_state_next = CTRL_IDLE;
        end else if (r_wdog == WDOG_LAST) begin
          w_error      = 1'b1;
          w_state_next = CTRL_IDLE;
        end else begin
          w_wdog_next = r_wdog + 1'b1;
        end
      end
      default: w_state_next = CTRL_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decision so that start pulses
  // coincide with the START states and ready with the return to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= CTRL_IDLE;
      r_wdog         <= '0;
      r_ready        <= 1'b1;
      r_key_valid    <= 1'b0;
      r_result_valid <= 1'b0;
      r_error        <= 1'b0;
      r_km_init      <= 1'b0;
      r_enc_next     <= 1'b0;
      r_keylen       <= 2'd0;
      r_enc_block    <= '0;
      r_result       <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wdog     <= w_wdog_next;
      r_ready    <= (w_state_next == CTRL_IDLE);
      r_error    <= w_error;
      r_km_init  <= (w_state_next == CTRL_KEY_START);
      r_enc_next <= (w_state_next == CTRL_ENC_START);
      if (w_accept_init) begin
        r_keylen    <= keylen;
        r_key_valid <= 1'b0;
      end
      if (w_key_done) r_key_valid <= 1'b1;
      if (w_accept_next) begin
        r_enc_block    <= block_in;
        r_result_valid <= 1'b0;
      end
      if (w_enc_done) begin
        r_result       <= enc_new_block;
        r_result_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    sboxw = 32'h0;
    case (r_state)
      CTRL_KEY_START, CTRL_KEY_WAIT: sboxw = km_sboxw;
      CTRL_ENC_START, CTRL_ENC_WAIT: sboxw = enc_sboxw;
      default:                       sboxw = 32'h0;
    endcase
  end

  assign ready        = r_ready;
  assign key_valid    = r_key_valid;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign error        = r_error;
  assign keylen_o     = r_keylen;
  assign km_init      = r_km_init;
  assign enc_next     = r_enc_next;
  assign enc_block    = r_enc_block;

endmodule

// File: tb/tb_aes_core_ctrl.sv
// Directed bench for aes_core_ctrl with behavioural key-memory and encipher
// stubs whose ready drops on the start pulse and returns after a set latency.
module tb_aes_core_ctrl;

  localparam int TMO = 16;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         init = 1'b0;
  logic         next = 1'b0;
  logic [1:0]   keylen = 2'd0;
  logic [127:0] block_in = '0;
  logic         ready, key_valid, result_valid, error;
  logic [127:0] result, enc_block;
  logic [1:0]   keylen_o;
  logic         km_init, enc_next;
  logic         km_ready, enc_ready;
  logic [31:0]  km_sboxw = 32'hdeadbeef;
  logic [31:0]  enc_sboxw = 32'h12345678;
  logic [127:0] enc_new_block = '0;
  logic [31:0]  sboxw;

  int total = 0;
  int bad = 0;
  int err_cnt = 0;
  int km_pulses = 0;
  int enc_pulses = 0;
  int km_lat = 3;
  int enc_lat = 5;
  int km_cnt, enc_cnt;
  bit enc_stuck = 1'b0;

  aes_core_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .init(init), .next(next), .keylen(keylen),
    .block_in(block_in), .ready(ready), .key_valid(key_valid), .result(result),
    .result_valid(result_valid), .error(error), .keylen_o(keylen_o),
    .km_init(km_init), .km_ready(km_ready), .km_sboxw(km_sboxw),
    .enc_next(enc_next), .enc_ready(enc_ready), .enc_sboxw(enc_sboxw),
    .enc_block(enc_block), .enc_new_block(enc_new_block), .sboxw(sboxw)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      km_ready <= 1'b1;
      km_cnt   <= 0;
    end else if (km_init) begin
      km_ready <= 1'b0;
      km_cnt   <= km_lat;
    end else if (!km_ready) begin
      if (km_cnt <= 1) km_ready <= 1'b1;
      km_cnt <= km_cnt - 1;
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enc_ready <= 1'b1;
      enc_cnt   <= 0;
    end else if (enc_next) begin
      enc_ready <= 1'b0;
      enc_cnt   <= enc_lat;
    end else if (!enc_ready && !enc_stuck) begin
      if (enc_cnt <= 1) enc_ready <= 1'b1;
      enc_cnt <= enc_cnt - 1;
    end
  end

  always @(negedge clk) begin
    if (error === 1'b1) err_cnt++;
    if (km_init === 1'b1) km_pulses++;
    if (enc_next === 1'b1) enc_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", ready); end
    total++; if (key_valid !== 1'b0 || result_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got kv=%b rv=%b want 0 0", key_valid, result_valid); end
    total++; if (result !== 128'h0 || enc_block !== 128'h0) begin bad++; $display("FAIL rst_data: got res=%h blk=%h want 0", result, enc_block); end
    total++; if (sboxw !== 32'h0) begin bad++; $display("FAIL rst_sboxw: got %h want 0", sboxw); end
    total++; if (km_init !== 1'b0 || enc_next !== 1'b0 || error !== 1'b0 || keylen_o !== 2'd0) begin bad++; $display("FAIL rst_ctrl: got km=%b en=%b err=%b kl=%0d want 0", km_init, enc_next, error, keylen_o); end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    total++; if (ready !== 1'b1 || km_init !== 1'b0 || enc_next !== 1'b0) begin bad++; $display("FAIL rst_release: got rdy=%b km=%b en=%b want 1 0 0", ready, km_init, enc_next); end
  endtask

  task automatic test_illegal();
    int p0;
    p0 = enc_pulses;
    next = 1'b1;
    tick();
    next = 1'b0;
    total++; if (error !== 1'b1 || ready !== 1'b1) begin bad++; $display("FAIL next_nokey: got err=%b rdy=%b want 1 1", error, ready); end
    tick();
    total++; if (error !== 1'b0) begin bad++; $display("FAIL next_nokey_pulse: got err=%b want 0", error); end
    total++; if (enc_pulses != p0) begin bad++; $display("FAIL next_nokey_start: got %0d enc_next pulses want 0", enc_pulses - p0); end
    init = 1'b1; keylen = 2'd3;
    tick();
    init = 1'b0; keylen = 2'd0;
    total++; if (error !== 1'b1 || km_init !== 1'b0 || ready !== 1'b1) begin bad++; $display("FAIL init_kl3: got err=%b km=%b rdy=%b want 1 0 1", error, km_init, ready); end
    tick();
    total++; if (error !== 1'b0 || key_valid !== 1'b0) begin bad++; $display("FAIL init_kl3_after: got err=%b kv=%b want 0 0", error, key_valid); end
  endtask

  task automatic test_keyexp(input logic [1:0] kl, input bit with_next, input int exp_cyc);
    int n, e0, k0;
    e0 = err_cnt; k0 = enc_pulses;
    init = 1'b1; keylen = kl; next = with_next;
    tick();
    init = 1'b0; next = 1'b0; keylen = 2'd3;
    n = 1;
    total++; if (km_init !== 1'b1 || enc_next !== 1'b0 || ready !== 1'b0 || key_valid !== 1'b0) begin bad++; $display("FAIL key_start: got km=%b en=%b rdy=%b kv=%b want 1 0 0 0", km_init, enc_next, ready, key_valid); end
    total++; if (keylen_o !== kl) begin bad++; $display("FAIL key_keylen: got %0d want %0d", keylen_o, kl); end
    while (ready !== 1'b1 && n < 40) begin
      tick(); n++;
      if (n == 2) begin
        total++; if (sboxw !== 32'hdeadbeef || km_init !== 1'b0) begin bad++; $display("FAIL key_sboxw: got %h km=%b want deadbeef 0", sboxw, km_init); end
      end
    end
    total++; if (n != exp_cyc) begin bad++; $display("FAIL key_latency: got %0d cycles want %0d", n, exp_cyc); end
    total++; if (key_valid !== 1'b1 || keylen_o !== kl || sboxw !== 32'h0) begin bad++; $display("FAIL key_done: got kv=%b kl=%0d sbox=%h want 1 %0d 0", key_valid, keylen_o, sboxw, kl); end
    total++; if (err_cnt != e0 || enc_pulses != k0) begin bad++; $display("FAIL key_noerr: got %0d errors %0d enc_next want 0 0", err_cnt - e0, enc_pulses - k0); end
  endtask

  task automatic test_encrypt(input logic [127:0] pt, input logic [127:0] ct, input logic [1:0] kl);
    int n, e0;
    e0 = err_cnt;
    enc_new_block = ct;
    next = 1'b1; block_in = pt;
    tick();
    next = 1'b0; block_in = ~pt;
    n = 1;
    total++; if (enc_next !== 1'b1 || enc_block !== pt || result_valid !== 1'b0 || ready !== 1'b0) begin bad++; $display("FAIL enc_start: got en=%b blk=%h rv=%b rdy=%b want 1 %h 0 0", enc_next, enc_block, result_valid, ready, pt); end
    while (ready !== 1'b1 && n < 40) begin
      tick(); n++;
      if (n == 2) begin
        total++; if (sboxw !== 32'h12345678 || enc_next !== 1'b0) begin bad++; $display("FAIL enc_sboxw: got %h en=%b want 12345678 0", sboxw, enc_next); end
      end
    end
    total++; if (n != enc_lat + 3) begin bad++; $display("FAIL enc_latency: got %0d cycles want %0d", n, enc_lat + 3); end
    total++; if (result !== ct || result_valid !== 1'b1) begin bad++; $display("FAIL enc_result: got %h rv=%b want %h 1", result, result_valid, ct); end
    total++; if (enc_block !== pt || keylen_o !== kl || err_cnt != e0) begin bad++; $display("FAIL enc_hold: got blk=%h kl=%0d errs=%0d want %h %0d 0", enc_block, keylen_o, err_cnt - e0, pt, kl); end
  endtask

  task automatic test_cmd_during_wait();
    int n;
    km_lat = 6;
    init = 1'b1; keylen = 2'd2;
    tick(); init = 1'b0;
    tick();
    next = 1'b1;
    tick(); next = 1'b0;
    n = 3;
    total++; if (error !== 1'b1 || ready !== 1'b0 || enc_next !== 1'b0) begin bad++; $display("FAIL wait_cmd_err: got err=%b rdy=%b en=%b want 1 0 0", error, ready, enc_next); end
    tick(); n++;
    total++; if (error !== 1'b0 || sboxw !== 32'hdeadbeef) begin bad++; $display("FAIL wait_cmd_state: got err=%b sbox=%h want 0 deadbeef", error, sboxw); end
    while (ready !== 1'b1 && n < 40) begin tick(); n++; end
    total++; if (n != 9 || key_valid !== 1'b1 || keylen_o !== 2'd2) begin bad++; $display("FAIL wait_cmd_done: got n=%0d kv=%b kl=%0d want 9 1 2", n, key_valid, keylen_o); end
    km_lat = 3;
  endtask

  task automatic test_timeout(input logic [127:0] prev);
    int early;
    early = 0;
    enc_stuck = 1'b1;
    enc_new_block = 128'hffff;
    next = 1'b1; block_in = PT;
    tick(); next = 1'b0;
    tick();
    for (int i = 1; i < TMO; i++) begin
      tick();
      if (error !== 1'b0 || ready !== 1'b0) early++;
    end
    total++; if (early != 0) begin bad++; $display("FAIL tmo_early: got %0d early cycles want 0", early); end
    tick();
    total++; if (error !== 1'b1 || ready !== 1'b1) begin bad++; $display("FAIL tmo_fire: got err=%b rdy=%b want 1 1", error, ready); end
    total++; if (result_valid !== 1'b0 || result !== prev) begin bad++; $display("FAIL tmo_result: got %h rv=%b want %h 0", result, result_valid, prev); end
    tick();
    total++; if (error !== 1'b0 || key_valid !== 1'b1) begin bad++; $display("FAIL tmo_after: got err=%b kv=%b want 0 1", error, key_valid); end
    enc_stuck = 1'b0;
    tick(); tick(); tick(); tick(); tick(); tick();
  endtask

  task automatic test_reset_mid();
    next = 1'b1; block_in = PT;
    tick(); next = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    total++; if (ready !== 1'b1 || key_valid !== 1'b0 || result_valid !== 1'b0 || result !== 128'h0 || sboxw !== 32'h0 || enc_block !== 128'h0) begin bad++; $display("FAIL mid_reset: got rdy=%b kv=%b rv=%b res=%h sbox=%h want 1 0 0 0 0", ready, key_valid, result_valid, result, sboxw); end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_keyexp(2'd0, 1'b0, 6);
    test_encrypt(PT, CT128, 2'd0);
    test_keyexp(2'd1, 1'b0, 6);
    test_encrypt(PT, CT192, 2'd1);
    test_encrypt(~PT, CT128, 2'd1);
    test_keyexp(2'd0, 1'b1, 6);
    test_cmd_during_wait();
    test_encrypt(PT, CT192, 2'd2);
    test_timeout(CT192);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
